g_event_logger: RTL and testbench
=================================

# g_event_logger

Downstream consumer of the integrator's single-bit `G` output. It detects rising edges of `G` and stamps each one with a free-running cycle count. The stamps are buffered in a small FIFO, and a host or monitor drains them over a valid/ready read port. This gives a cycle-accurate record of when the integrator asserted `G`, and it tolerates read back-pressure.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `TS_WIDTH`, 8: timestamp width; the timestamp wraps modulo 2^TS_WIDTH.
- `CLK` input 1: single clock; all state changes on its rising edge.
- `RESET` input 1: asynchronous, active-high reset.
- `G` input 1: event input, driven by the integrator's registered `G`.
- `ARM` input 1: capture enable; edges seen while `ARM`=0 are discarded.
- `CLR_OVF` input 1: synchronous clear of `OVERFLOW`.
- `RD_READY` input 1: reader accepts the head entry.
- `RD_VALID` output 1: FIFO not empty.
- `RD_TS` output TS_WIDTH: timestamp of the head entry.
- `COUNT` output $clog2(DEPTH)+1: number of stored entries.
- `OVERFLOW` output 1: sticky flag; an armed edge was dropped because the FIFO was full.

## Operation
- **Reset values.** While `RESET` is high, all of the following are held at 0:
  - `RD_VALID`, `RD_TS`, `COUNT`, `OVERFLOW`
  - the timestamp counter `ts`
  - the edge register `g_q`
  - the read and write pointers
- **Reset mid-operation.** Stored entries are discarded. No partial push or pop survives.
- **Timestamp counter.** `ts` is 0 in the first cycle after `RESET` falls and increments by 1 every cycle. It wraps from 2^TS_WIDTH−1 to 0 without any flag.
- **Edge detect.**
  - `g_q` registers `G` every cycle, regardless of `ARM`.
  - `edge = G & ~g_q`.
  - `G` held high for N cycles produces exactly one edge.
  - `G` low-high-low-high produces two edges.
- **Push.** Occurs when `edge & ARM`. The stored value is `ts` sampled in the same cycle that `G` is first high.
- **Pop.** Occurs when `RD_VALID & RD_READY`. `RD_READY` is ignored while `RD_VALID`=0.
- **Full, push without pop.** The event is dropped, `OVERFLOW` is set, and the contents are unchanged.
- **Full, push and pop in the same cycle.** Both take effect, `COUNT` stays at `DEPTH`, and `OVERFLOW` is not set.
- **Empty, push.** The entry becomes visible on the next cycle. The read port has no bypass.
- **OVERFLOW clear.**
  - `OVERFLOW` clears only on `RESET` or `CLR_OVF`=1.
  - If `CLR_OVF` and a new drop occur in the same cycle, set wins and `OVERFLOW` stays 1.
- **Ordering.** Strictly first in, first out. Timestamps out are in capture order, including across wrap.

## Timing
- **Capture latency.** From the edge where `G` is first sampled high to `RD_VALID`/`RD_TS` updated is 1 cycle, when the FIFO was empty.
- **Output stability.**
  - `RD_TS` is stable while `RD_VALID`=1 and `RD_READY`=0.
  - `RD_TS` advances to the next entry in the cycle after a pop.
  - `RD_TS` holds its last value when the FIFO drains; its value is don't-care while `RD_VALID`=0.
- **COUNT.** Updates one cycle after each push or pop: +1, −1, or 0 for a simultaneous push and pop.
- **Throughput.** Sustains one push and one pop per cycle.
- **Register placement.** All outputs come directly from registers or from the storage read mux. There is no combinational path from `G` or `RD_READY` to any output.

## Structure
- **Package `g_logger_pkg`:**
  - defaults `DEPTH_DEF`=4 and `TS_WIDTH_DEF`=8;
  - the pointer-width helper constant `PTR_W`=$clog2(DEPTH).
- **Sub-module `ts_fifo`:** a synchronous FIFO with DEPTH×TS_WIDTH storage.
  - Pointers are PTR_W+1 bits wide; an extra wrap bit distinguishes full from empty.
  - Ports: push and push data; pop and pop data; count; full; empty.
- **Top level:** the timestamp counter, the edge detector, the `ARM` gating, the overflow flag, and one `ts_fifo` instance.

## Test plan
- **Reset and single edge.** Assert `RESET` for 3 cycles, then release; `ARM`=1; pulse `G` for 1 cycle at ts=5. Required: `RD_VALID`=0 until the next cycle, then `RD_VALID`=1, `RD_TS`=5, `COUNT`=1. Pop with `RD_READY`=1. Required: `RD_VALID`=0 and `COUNT`=0 on the next cycle.
- **Level hold.** Hold `G` high for 10 cycles starting at ts=20, with `ARM`=1. Required: exactly one entry with `RD_TS`=20 and `COUNT`=1.
- **Fill and overflow.** `DEPTH`=4, `RD_READY`=0; 5 single-cycle pulses at ts=10,12,14,16,18. Required: `COUNT`=4 and `OVERFLOW`=1 from ts=19. Draining yields 10,12,14,16. `CLR_OVF` pulse, then `OVERFLOW`=0.
- **Full with simultaneous push and pop.** FIFO full with head 10; pulse `G` with `RD_READY`=1 in the same cycle at ts=30. Required: `COUNT` stays 4, `OVERFLOW`=0, and the tail entry is 30.
- **Disarmed.** `ARM`=0; 3 pulses. Required: `COUNT`=0 and `OVERFLOW`=0. Then set `ARM`=1 while `G` is already high. Required: no entry is logged, because `g_q` tracked `G`.
- **Wrap, then reset mid-operation.**
  - `TS_WIDTH`=8; pulse at cycle 257 after reset. Required: `RD_TS`=1.
  - With 2 entries queued, assert `RESET` asynchronously between clock edges. Required: `RD_VALID`, `COUNT` and `OVERFLOW` go to 0 immediately.

Source files
------------

// File: rtl/g_logger_pkg.sv
// g_logger_pkg: shared defaults for the G event logger.
// Holds FIFO depth, timestamp width and pointer width.
package g_logger_pkg;

  localparam int DEPTH_DEF    = 4;
  localparam int TS_WIDTH_DEF = 8;
  localparam int PTR_W        = $clog2(DEPTH_DEF);

endpackage

// File: rtl/ts_fifo.sv
// ts_fifo: synchronous DEPTH x W FIFO with wrap-bit pointers.
// Ports: push/push_data in, pop/pop_data out, count, full, empty.
module ts_fifo
  import g_logger_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = TS_WIDTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW:0]   wr_q, wr_d;
  logic [AW:0]   rd_q, rd_d;
  logic [AW-1:0] rd_idx;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count = wr_q - rd_q;

  // When empty, show the slot just popped so the
  // output holds its last value after draining.
  always_comb begin
    rd_idx = rd_q[AW-1:0];
    if (empty) rd_idx = rd_q[AW-1:0] - AW'(1);
  end

  assign pop_data = mem_q[rd_idx];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push) begin
      mem_d[wr_q[AW-1:0]] = push_data;
      wr_d = wr_q + (AW+1)'(1);
    end
    if (pop) rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end

endmodule

// File: rtl/g_event_logger.sv
// g_event_logger: timestamps rising edges of G into a FIFO.
// In: CLK RESET G ARM CLR_OVF RD_READY; out: RD_VALID RD_TS COUNT OVERFLOW.
module g_event_logger
  import g_logger_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int TS_WIDTH = TS_WIDTH_DEF
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   G,
  input  logic                   ARM,
  input  logic                   CLR_OVF,
  input  logic                   RD_READY,
  output logic                   RD_VALID,
  output logic [TS_WIDTH-1:0]    RD_TS,
  output logic [$clog2(DEPTH):0] COUNT,
  output logic                   OVERFLOW
);

  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic                g_q, g_d;
  logic                ovf_q, ovf_d;
  logic                g_rise;
  logic                push_req;
  logic                push;
  logic                pop;
  logic                drop;
  logic                full;
  logic                empty;

  assign g_rise   = G & ~g_q;
  assign push_req = g_rise & ARM;
  assign pop      = ~empty & RD_READY;
  // A pop in the same cycle frees the slot the push needs.
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_comb begin
    ts_d  = ts_q + TS_WIDTH'(1);
    g_d   = G;
    ovf_d = ovf_q;
    if (CLR_OVF) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ts_q  <= '0;
      g_q   <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      ts_q  <= ts_d;
      g_q   <= g_d;
      ovf_q <= ovf_d;
    end
  end

  ts_fifo #(
    .DEPTH (DEPTH),
    .W     (TS_WIDTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RESET),
    .push      (push),
    .push_data (ts_q),
    .pop       (pop),
    .pop_data  (RD_TS),
    .count     (COUNT),
    .full      (full),
    .empty     (empty)
  );

  assign RD_VALID = ~empty;
  assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_g_event_logger.sv
// tb_g_event_logger: directed self-checking bench for g_event_logger.
// cyc mirrors the expected timestamp of the open cycle.
module tb_g_event_logger;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       G = 1'b0;
  logic       ARM = 1'b0;
  logic       CLR_OVF = 1'b0;
  logic       RD_READY = 1'b0;
  logic       RD_VALID;
  logic [7:0] RD_TS;
  logic [2:0] COUNT;
  logic       OVERFLOW;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  g_event_logger #(
    .DEPTH    (4),
    .TS_WIDTH (8)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .G        (G),
    .ARM      (ARM),
    .CLR_OVF  (CLR_OVF),
    .RD_READY (RD_READY),
    .RD_VALID (RD_VALID),
    .RD_TS    (RD_TS),
    .COUNT    (COUNT),
    .OVERFLOW (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic goto_ts(input int t);
    while (cyc < t) step();
  endtask

  task automatic pulse_at(input int t);
    goto_ts(t);
    G = 1'b1;
    step();
    G = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    G = 1'b0;
    ARM = 1'b1;
    CLR_OVF = 1'b0;
    RD_READY = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    ARM = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    n_tests++;
    if (RD_VALID !== 1'b0 || COUNT !== 3'd0 ||
        OVERFLOW !== 1'b0 || RD_TS !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_vals got v=%b c=%0d o=%b ts=%0d exp 0 0 0 0",
               RD_VALID, COUNT, OVERFLOW, RD_TS);
    end
    RESET = 1'b0;
    cyc = 0;
  endtask

  task automatic test_single_edge();
    goto_ts(5);
    n_tests++;
    if (RD_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pre_valid got %b exp 0", RD_VALID);
    end
    G = 1'b1;
    step();
    G = 1'b0;
    n_tests++;
    if (RD_VALID !== 1'b1 || RD_TS !== 8'd5 || COUNT !== 3'd1) begin
      n_fail++;
      $display("FAIL single_capture got v=%b ts=%0d c=%0d exp 1 5 1",
               RD_VALID, RD_TS, COUNT);
    end
    RD_READY = 1'b1;
    step();
    RD_READY = 1'b0;
    n_tests++;
    if (RD_VALID !== 1'b0 || COUNT !== 3'd0) begin
      n_fail++;
      $display("FAIL single_pop got v=%b c=%0d exp 0 0",
               RD_VALID, COUNT);
    end
  endtask

  task automatic test_level_hold();
    do_reset();
    goto_ts(20);
    G = 1'b1;
    repeat (10) step();
    G = 1'b0;
    step();
    n_tests++;
    if (RD_VALID !== 1'b1 || RD_TS !== 8'd20 || COUNT !== 3'd1) begin
      n_fail++;
      $display("FAIL level_hold got v=%b ts=%0d c=%0d exp 1 20 1",
               RD_VALID, RD_TS, COUNT);
    end
  endtask

  task automatic test_fill_overflow();
    int pts [5] = '{10, 12, 14, 16, 18};
    int exp_ts [4] = '{10, 12, 14, 16};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        goto_ts(pts[i]);
        n_tests++;
        if (COUNT !== 3'd4 || OVERFLOW !== 1'b0) begin
          n_fail++;
          $display("FAIL fill_full got c=%0d o=%b exp 4 0",
                   COUNT, OVERFLOW);
        end
      end
      pulse_at(pts[i]);
    end
    n_tests++;
    if (COUNT !== 3'd4 || OVERFLOW !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_ovf got c=%0d o=%b exp 4 1", COUNT, OVERFLOW);
    end
    goto_ts(20);
    G = 1'b1;
    CLR_OVF = 1'b1;
    step();
    G = 1'b0;
    CLR_OVF = 1'b0;
    n_tests++;
    if (OVERFLOW !== 1'b1 || COUNT !== 3'd4) begin
      n_fail++;
      $display("FAIL ovf_set_wins got o=%b c=%0d exp 1 4",
               OVERFLOW, COUNT);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (RD_VALID !== 1'b1 || RD_TS !== 8'(exp_ts[i])) begin
        n_fail++;
        $display("FAIL fill_drain%0d got v=%b ts=%0d exp 1 %0d",
                 i, RD_VALID, RD_TS, exp_ts[i]);
      end
      RD_READY = 1'b1;
      step();
      RD_READY = 1'b0;
    end
    n_tests++;
    if (RD_VALID !== 1'b0 || COUNT !== 3'd0 ||
        RD_TS !== 8'd16 || OVERFLOW !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_empty got v=%b c=%0d ts=%0d o=%b exp 0 0 16 1",
               RD_VALID, COUNT, RD_TS, OVERFLOW);
    end
    CLR_OVF = 1'b1;
    step();
    CLR_OVF = 1'b0;
    n_tests++;
    if (OVERFLOW !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear got %b exp 0", OVERFLOW);
    end
  endtask

  task automatic test_full_push_pop();
    int exp_ts [4] = '{12, 14, 16, 30};
    do_reset();
    pulse_at(10);
    pulse_at(12);
    pulse_at(14);
    pulse_at(16);
    goto_ts(30);
    G = 1'b1;
    RD_READY = 1'b1;
    step();
    G = 1'b0;
    RD_READY = 1'b0;
    n_tests++;
    if (COUNT !== 3'd4 || OVERFLOW !== 1'b0 || RD_TS !== 8'd12) begin
      n_fail++;
      $display("FAIL full_pushpop got c=%0d o=%b ts=%0d exp 4 0 12",
               COUNT, OVERFLOW, RD_TS);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (RD_VALID !== 1'b1 || RD_TS !== 8'(exp_ts[i])) begin
        n_fail++;
        $display("FAIL full_drain%0d got v=%b ts=%0d exp 1 %0d",
                 i, RD_VALID, RD_TS, exp_ts[i]);
      end
      RD_READY = 1'b1;
      step();
      RD_READY = 1'b0;
    end
  endtask

  task automatic test_disarmed();
    do_reset();
    ARM = 1'b0;
    pulse_at(5);
    pulse_at(7);
    pulse_at(9);
    step();
    n_tests++;
    if (COUNT !== 3'd0 || OVERFLOW !== 1'b0 || RD_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL disarmed got c=%0d o=%b v=%b exp 0 0 0",
               COUNT, OVERFLOW, RD_VALID);
    end
    G = 1'b1;
    step();
    step();
    ARM = 1'b1;
    repeat (3) step();
    G = 1'b0;
    step();
    n_tests++;
    if (COUNT !== 3'd0) begin
      n_fail++;
      $display("FAIL arm_while_high got c=%0d exp 0", COUNT);
    end
    pulse_at(cyc + 2);
    n_tests++;
    if (COUNT !== 3'd1 || RD_TS !== 8'(cyc - 1)) begin
      n_fail++;
      $display("FAIL rearmed got c=%0d ts=%0d exp 1 %0d",
               COUNT, RD_TS, cyc - 1);
    end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    pulse_at(254);
    pulse_at(257);
    pulse_at(260);
    n_tests++;
    if (COUNT !== 3'd3 || RD_TS !== 8'd254) begin
      n_fail++;
      $display("FAIL wrap_head got c=%0d ts=%0d exp 3 254", COUNT, RD_TS);
    end
    RD_READY = 1'b1;
    step();
    RD_READY = 1'b0;
    n_tests++;
    if (COUNT !== 3'd2 || RD_TS !== 8'd1) begin
      n_fail++;
      $display("FAIL wrap_ts got c=%0d ts=%0d exp 2 1", COUNT, RD_TS);
    end
    #3;
    RESET = 1'b1;
    #1;
    n_tests++;
    if (RD_VALID !== 1'b0 || COUNT !== 3'd0 || OVERFLOW !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got v=%b c=%0d o=%b exp 0 0 0",
               RD_VALID, COUNT, OVERFLOW);
    end
    @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_level_hold();
    test_fill_overflow();
    test_full_push_pop();
    test_disarmed();
    test_wrap_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
